// File: rtl/and2_tuple_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : and2_tuple_rr_arbiter
// Purpose  : Round-robin sharing of one Tuple(x,y) And2 unit with a
//            registered, id-tagged response channel.
// Revision : 1.0
// ============================================================================

module and2_tuple (
    input  logic I0_x,
    input  logic I0_y,
    input  logic I1_x,
    input  logic I1_y,
    output logic O_x,
    output logic O_y
);
    assign O_x = I0_x & I1_x;
    assign O_y = I0_y & I1_y;
endmodule

module and2_tuple_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    input  logic [N_REQ-1:0] req_I0_x,
    input  logic [N_REQ-1:0] req_I0_y,
    input  logic [N_REQ-1:0] req_I1_x,
    input  logic [N_REQ-1:0] req_I1_y,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [ID_W-1:0]  resp_id,
    output logic             resp_O_x,
    output logic             resp_O_y
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win;
    logic            found;
    logic            can_accept;
    logic            accept;
    logic            and_x;
    logic            and_y;

    // Scan from ptr upward with wrap; first valid requester wins.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_s;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx   = (int'(ptr) + k) % N_REQ;
            idx_s = idx[ID_W-1:0];
            if (!found && req_valid[idx_s]) begin
                found = 1'b1;
                win   = idx_s;
            end
        end
    end

    assign can_accept = (state == IDLE) | ((state == HOLD) & resp_ready);
    assign accept     = found & can_accept & ~ASYNCRESET;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

    and2_tuple u_and2 (
        .I0_x (req_I0_x[win]),
        .I0_y (req_I0_y[win]),
        .I1_x (req_I1_x[win]),
        .I1_y (req_I1_y[win]),
        .O_x  (and_x),
        .O_y  (and_y)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_next = HOLD;
                end else if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Data and id registers only move on accept; a drain keeps their values.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            ptr      <= '0;
            resp_id  <= '0;
            resp_O_x <= 1'b0;
            resp_O_y <= 1'b0;
        end else if (accept) begin
            ptr      <= (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
            resp_id  <= win;
            resp_O_x <= and_x;
            resp_O_y <= and_y;
        end
    end

    assign resp_valid = (state == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_and2_tuple_rr_arbiter.sv
`default_nettype none
// Testbench for and2_tuple_rr_arbiter: directed vectors, expected responses
// queued by stimulus and checked by an independent monitor.

module tb_and2_tuple_rr_arbiter;
    logic       CLK;
    logic       ASYNCRESET;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [3:0] req_I0_x;
    logic [3:0] req_I0_y;
    logic [3:0] req_I1_x;
    logic [3:0] req_I1_y;
    logic       resp_valid;
    logic       resp_ready;
    logic [1:0] resp_id;
    logic       resp_O_x;
    logic       resp_O_y;

    typedef struct {
        logic [1:0] id;
        logic       ox;
        logic       oy;
    } resp_t;

    resp_t q[$];
    int    checks = 0;
    int    errors = 0;

    and2_tuple_rr_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_I0_x   (req_I0_x),
        .req_I0_y   (req_I0_y),
        .req_I1_x   (req_I1_x),
        .req_I1_y   (req_I1_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_O_x   (resp_O_x),
        .resp_O_y   (resp_O_y)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic ox, input logic oy);
        resp_t e;
        e.id = id;
        e.ox = ox;
        e.oy = oy;
        q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic rr);
        req_valid  = v;
        resp_ready = rr;
        #1;
    endtask

    // Monitor: a handshake seen at negedge completes at the following posedge.
    always @(negedge CLK) begin
        resp_t e;
        if (!ASYNCRESET) begin
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: actual id=%0d required=no response", resp_id);
                end else begin
                    e = q.pop_front();
                    chk("resp_id", 32'(resp_id), 32'(e.id));
                    chk("resp_O_x", 32'(resp_O_x), 32'(e.ox));
                    chk("resp_O_y", 32'(resp_O_y), 32'(e.oy));
                end
            end
        end
    end

    initial begin
        ASYNCRESET = 1'b1;
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        req_I0_x   = 4'b0000;
        req_I0_y   = 4'b0000;
        req_I1_x   = 4'b0000;
        req_I1_y   = 4'b0000;
        #2;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_O", 32'({resp_O_x, resp_O_y}), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        next_cycle();
        req_valid  = 4'b0000;
        ASYNCRESET = 1'b0;

        // Single request from requester 0: O_x=1&1, O_y=1&0.
        next_cycle();
        req_I0_x = 4'b0001;
        req_I0_y = 4'b0001;
        req_I1_x = 4'b0001;
        req_I1_y = 4'b0000;
        drive(4'b0001, 1'b1);
        chk("single_ready", 32'(req_ready), 32'h1);
        push(2'd0, 1'b1, 1'b0);
        next_cycle();
        drive(4'b0000, 1'b1);
        chk("single_valid", 32'(resp_valid), 32'd1);
        // Drain: response leaves, data registers hold.
        next_cycle();
        chk("drain_valid", 32'(resp_valid), 32'd0);
        chk("drain_O", 32'({resp_O_x, resp_O_y}), 32'b10);

        // Reset mid-HOLD: ptr=1, requester 2 wins.
        req_I0_x = 4'b0100;
        req_I0_y = 4'b0100;
        req_I1_x = 4'b0100;
        req_I1_y = 4'b0100;
        drive(4'b0100, 1'b0);
        chk("rsthold_ready", 32'(req_ready), 32'h4);
        next_cycle();
        drive(4'b0000, 1'b0);
        chk("rsthold_held", 32'({resp_valid, resp_id, resp_O_x, resp_O_y}), 32'b11011);
        #1;
        ASYNCRESET = 1'b1;
        #1;
        chk("rsthold_cleared", 32'({resp_valid, resp_O_x, resp_O_y}), 32'd0);
        ASYNCRESET = 1'b0;

        // Round-robin from ptr=0 with all requesters active.
        next_cycle();
        req_I0_x = 4'b1111;
        req_I1_x = 4'b0101;
        req_I0_y = 4'b0011;
        req_I1_y = 4'b1111;
        drive(4'b1111, 1'b1);
        chk("rr_grant0", 32'(req_ready), 32'h1);
        push(2'd0, 1'b1, 1'b1);
        next_cycle();
        chk("rr_grant1", 32'(req_ready), 32'h2);
        push(2'd1, 1'b0, 1'b1);
        next_cycle();
        chk("rr_grant2", 32'(req_ready), 32'h4);
        push(2'd2, 1'b1, 1'b0);
        next_cycle();
        chk("rr_grant3", 32'(req_ready), 32'h8);
        push(2'd3, 1'b0, 1'b0);
        next_cycle();
        chk("rr_grant0_wrap", 32'(req_ready), 32'h1);
        push(2'd0, 1'b1, 1'b1);

        // Back-pressure: ptr=1, requester 1 wins, then stall.
        next_cycle();
        drive(4'b0110, 1'b1);
        chk("bp_grant1", 32'(req_ready), 32'h2);
        push(2'd1, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            drive(4'b0110, 1'b0);
            chk("bp_ready_zero", 32'(req_ready), 32'h0);
            chk("bp_stable", 32'({resp_valid, resp_id, resp_O_x, resp_O_y}), 32'b10101);
        end
        next_cycle();
        drive(4'b0110, 1'b1);
        chk("bp_bypass_grant2", 32'(req_ready), 32'h4);
        push(2'd2, 1'b1, 1'b0);

        // Wrap and skip: ptr=3 with 0101 -> 0, then 2.
        next_cycle();
        drive(4'b0101, 1'b1);
        chk("wrap_grant0", 32'(req_ready), 32'h1);
        push(2'd0, 1'b1, 1'b1);
        next_cycle();
        drive(4'b0101, 1'b1);
        chk("skip_grant2", 32'(req_ready), 32'h4);
        push(2'd2, 1'b1, 1'b0);

        // Operand changes after accept must not disturb the held response.
        next_cycle();
        req_I0_x = 4'b0000;
        req_I0_y = 4'b0000;
        drive(4'b0000, 1'b0);
        next_cycle();
        chk("held_operands", 32'({resp_valid, resp_id, resp_O_x, resp_O_y}), 32'b11010);
        drive(4'b0000, 1'b1);
        next_cycle();
        chk("final_drain", 32'({resp_valid, resp_O_x, resp_O_y}), 32'b010);
        next_cycle();
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
